// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller for a single-issue RISC-V style core.
// Accepts one load/store request, spends one cycle performing the RAM access
// and reports completion with a one-cycle ready pulse.
//
// Ports:
//   clk       - single clock, all state updates on the rising edge
//   rst       - asynchronous, active-high reset
//   req       - access request, held high by the requester until ready
//   we        - 1 = store, 0 = load (sampled with req)
//   addr      - byte address; word index is addr[log2(DEPTH)+1:2]
//   wdata     - store data (low byte/half used for SB/SH)
//   f3        - funct3: access size and sign extension
//   ready     - one-cycle completion pulse
//   rdata     - load result, zero whenever ready=0
//   misalign  - 1 = access rejected (misaligned or illegal f3), zero whenever ready=0
//   dbg_state - current FSM state (IDLE=0, ACCESS=1, DONE=2)
//
// Handshake: req is sampled only in IDLE. The rising edge that sees req=1 in
// IDLE latches we/addr/wdata/f3; later input changes do not touch that access.
// The next edge performs the access and the cycle after it shows ready=1 with
// rdata/misalign valid. A requester that keeps req high gets one access every
// three cycles.

module dmem_ctrl #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  f3,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic [1:0]  dbg_state
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Latched request; only the address bits that reach the RAM are kept.
    logic          we_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [2:0]    f3_q;

    // Result captured at the end of ACCESS and presented during DONE.
    logic [31:0] rdata_q;
    logic        mis_q;

    logic [31:0] mem [DEPTH];

    // Address bits above the RAM size wrap and are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:AW+2];

    // ------------------------------------------------------------------
    // Access decode, driven only by the latched request
    // ------------------------------------------------------------------
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          legal_f3;
    logic          aligned;
    logic          ok;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic [31:0]   word;
    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;
    logic [31:0]   load_val;

    assign idx  = addr_q[AW+1:2];
    assign lane = addr_q[1:0];
    assign word = mem[idx];

    always_comb begin
        legal_f3 = 1'b0;
        aligned  = 1'b0;
        be       = 4'b0000;
        wd       = wdata_q;
        sel_byte = word[8*lane +: 8];
        sel_half = lane[1] ? word[31:16] : word[15:0];
        load_val = 32'h0;

        if (we_q) begin
            legal_f3 = (f3_q == 3'b000) || (f3_q == 3'b001) || (f3_q == 3'b010);
        end else begin
            legal_f3 = (f3_q == 3'b000) || (f3_q == 3'b001) || (f3_q == 3'b010) ||
                       (f3_q == 3'b100) || (f3_q == 3'b101);
        end

        case (f3_q[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~lane[0];
            2'b10:   aligned = (lane == 2'b00);
            default: aligned = 1'b0;
        endcase

        // Store data is replicated across lanes so the byte enables alone
        // pick which lanes change.
        case (f3_q[1:0])
            2'b00: begin
                be = 4'b0001 << lane;
                wd = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be = 4'b0011 << lane;
                wd = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                be = 4'b1111;
                wd = wdata_q;
            end
            default: begin
                be = 4'b0000;
                wd = wdata_q;
            end
        endcase

        case (f3_q)
            3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
            3'b010:  load_val = word;
            3'b100:  load_val = {24'h0, sel_byte};
            3'b101:  load_val = {16'h0, sel_half};
            default: load_val = 32'h0;
        endcase
    end

    assign ok = legal_f3 & aligned;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = req ? ACCESS : IDLE;
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch and result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            f3_q    <= 3'b000;
            rdata_q <= 32'h0;
            mis_q   <= 1'b0;
        end else begin
            if (state == IDLE && req) begin
                we_q    <= we;
                addr_q  <= addr[AW+1:0];
                wdata_q <= wdata;
                f3_q    <= f3;
            end
            if (state == ACCESS) begin
                mis_q   <= ~ok;
                rdata_q <= (ok && !we_q) ? load_val : 32'h0;
            end
        end
    end

    // RAM is never reset. Reset forces the FSM out of ACCESS immediately, so
    // an interrupted store never reaches this write port.
    always_ff @(posedge clk) begin
        if (state == ACCESS && we_q && ok) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wd[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: everything except dbg_state is gated by the DONE state
    // ------------------------------------------------------------------
    assign ready     = (state == DONE);
    assign rdata     = ready ? rdata_q : 32'h0;
    assign misalign  = ready & mis_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Testbench for dmem_ctrl. A behavioural memory model predicts every access
// result from the load/store rules; a per-cycle compare process checks the
// DUT outputs against it, and directed sequences pin literal values.

module tb_dmem_ctrl;

    localparam int DEPTH = 256;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [2:0]  f3 = 3'b000;
    logic        ready;
    logic [31:0] rdata;
    logic        misalign;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .f3        (f3),
        .ready     (ready),
        .rdata     (rdata),
        .misalign  (misalign),
        .dbg_state (dbg_state)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [31:0] ref_mem [DEPTH];
    logic [32:0] exp_q [$];   // {misalign, rdata}
    int          busy = 0;    // edges left until the latched access finishes
    bit          l_we;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic [2:0]  l_f3;
    logic [32:0] m_res;

    task automatic model_exec(input bit w, input logic [31:0] a, input logic [31:0] d,
                              input logic [2:0] f, output logic [32:0] res);
        int          nbytes;
        int          off;
        int          idx;
        bit          legal;
        logic [31:0] v;
        logic [31:0] mask;
        nbytes = 1 << f[1:0];
        off    = int'(a % 4);
        idx    = int'((a / 4) % DEPTH);
        if (w) legal = (f == 3'd0) || (f == 3'd1) || (f == 3'd2);
        else   legal = (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd5);
        if (!legal || (off % nbytes) != 0) begin
            res = {1'b1, 32'h0};
        end else if (w) begin
            for (int b = 0; b < nbytes; b++) begin
                ref_mem[idx][8*(off+b) +: 8] = d[8*b +: 8];
            end
            res = 33'h0;
        end else begin
            v = ref_mem[idx] >> (8 * off);
            if (nbytes < 4) begin
                mask = (32'h1 << (8 * nbytes)) - 32'h1;
                v = v & mask;
                if (!f[2] && v[8*nbytes-1]) v = v | ~mask;
            end
            res = {1'b0, v};
        end
    endtask

    // An access latched at edge N completes at edge N+1 (ready in the
    // following cycle); the controller is idle again from edge N+2 and can
    // latch the next request at edge N+3.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy = 0;
            exp_q.delete();
        end else if (busy == 2) begin
            model_exec(l_we, l_addr, l_wdata, l_f3, m_res);
            exp_q.push_back(m_res);
            busy = 1;
        end else if (busy == 1) begin
            busy = 0;
        end else if (req === 1'b1) begin
            l_we    = we;
            l_addr  = addr;
            l_wdata = wdata;
            l_f3    = f3;
            busy    = 2;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard compare, once per cycle on the falling edge
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        logic [32:0] e;
        if (cmp_en) begin
            if (rst) begin
                chk("rst_ready", ready, 0);
                chk("rst_rdata", rdata, 0);
                chk("rst_misalign", misalign, 0);
            end else begin
                chk("ready", ready, (busy == 1) ? 1 : 0);
                if (busy == 1) begin
                    chk("exp_q_size", exp_q.size(), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("rdata", rdata, e[31:0]);
                        chk("misalign", misalign, {31'h0, e[32]});
                    end
                end else begin
                    chk("rdata_idle", rdata, 0);
                    chk("misalign_idle", misalign, 0);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver: raise req, hold it until ready, scramble inputs after latch
    // ------------------------------------------------------------------
    task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] f, output logic [31:0] rd, output logic mis);
        int edges;
        bit seen;
        edges = 0;
        seen  = 1'b0;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; f3 = f;
        while (!seen && edges < 8) begin
            @(posedge clk);
            edges++;
            if (edges == 1) begin
                #1;
                we    = 1'($urandom_range(0, 1));
                addr  = $urandom();
                wdata = $urandom();
                f3    = 3'($urandom_range(0, 7));
            end
            @(negedge clk);
            if (ready === 1'b1) seen = 1'b1;
        end
        rd  = rdata;
        mis = misalign;
        req = 1'b0;
        chk("latency_edges", seen ? edges : 99, 2);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] rd;
        logic        mis;
        int          pulses;

        #2 rst = 1'b1;
        #1;
        chk("por_ready", ready, 0);
        chk("por_rdata", rdata, 0);
        chk("por_misalign", misalign, 0);
        chk("por_state", dbg_state, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Give every word a known value so random loads are predictable.
        for (int i = 0; i < DEPTH; i++) begin
            access(1'b1, 32'(i * 4), $urandom(), 3'b010, rd, mis);
        end

        // Word store/load
        access(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, rd, mis);
        chk("sw10_rdata", rd, 0);
        chk("sw10_mis", mis, 0);
        access(1'b0, 32'h10, 32'h0, 3'b010, rd, mis);
        chk("lw10", rd, 32'hDEADBEEF);
        chk("lw10_mis", mis, 0);

        // Byte store and signed/unsigned byte loads
        access(1'b1, 32'h11, 32'h00000080, 3'b000, rd, mis);
        access(1'b0, 32'h11, 32'h0, 3'b000, rd, mis);
        chk("lb11", rd, 32'hFFFFFF80);
        access(1'b0, 32'h11, 32'h0, 3'b100, rd, mis);
        chk("lbu11", rd, 32'h00000080);
        access(1'b0, 32'h10, 32'h0, 3'b010, rd, mis);
        chk("lw10_after_sb", rd, 32'hDEAD80EF);

        // Halfword store to the upper half
        access(1'b1, 32'h20, 32'h0000C0DE, 3'b010, rd, mis);
        access(1'b1, 32'h22, 32'h1234F00D, 3'b001, rd, mis);
        access(1'b0, 32'h22, 32'h0, 3'b001, rd, mis);
        chk("lh22", rd, 32'hFFFFF00D);
        access(1'b0, 32'h22, 32'h0, 3'b101, rd, mis);
        chk("lhu22", rd, 32'h0000F00D);
        access(1'b0, 32'h20, 32'h0, 3'b010, rd, mis);
        chk("lw20_after_sh", rd, 32'hF00DC0DE);

        // Rejected accesses leave memory alone
        access(1'b1, 32'h14, 32'h55667788, 3'b010, rd, mis);
        access(1'b0, 32'h13, 32'h0, 3'b010, rd, mis);
        chk("lw13_mis", mis, 1);
        chk("lw13_rdata", rd, 0);
        access(1'b1, 32'h15, 32'h0000FFFF, 3'b001, rd, mis);
        chk("sh15_mis", mis, 1);
        chk("sh15_rdata", rd, 0);
        access(1'b0, 32'h14, 32'h0, 3'b011, rd, mis);
        chk("lb_f3_011_mis", mis, 1);
        chk("lb_f3_011_rdata", rd, 0);
        access(1'b1, 32'h14, 32'hFFFFFFFF, 3'b011, rd, mis);
        chk("st_f3_011_mis", mis, 1);
        access(1'b0, 32'h14, 32'h0, 3'b010, rd, mis);
        chk("lw14_unchanged", rd, 32'h55667788);
        chk("lw14_mis", mis, 0);

        // Address wrap at DEPTH words
        access(1'b1, 32'h400, 32'h5, 3'b010, rd, mis);
        access(1'b0, 32'h0, 32'h0, 3'b010, rd, mis);
        chk("wrap_lw0", rd, 32'h5);

        // Reset during ACCESS aborts the store
        access(1'b1, 32'h30, 32'hAAAAAAAA, 3'b010, rd, mis);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'h11111111; f3 = 3'b010;
        @(posedge clk);
        #1;
        req = 1'b0;
        chk("pre_rst_state_access", dbg_state, 1);
        rst = 1'b1;
        #1;
        chk("abort_ready", ready, 0);
        chk("abort_rdata", rdata, 0);
        chk("abort_misalign", misalign, 0);
        chk("abort_state", dbg_state, 0);
        #1 rst = 1'b0;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (ready === 1'b1) pulses++;
        end
        chk("abort_no_ready", pulses, 0);
        access(1'b0, 32'h30, 32'h0, 3'b010, rd, mis);
        chk("lw30_after_abort", rd, 32'hAAAAAAAA);

        // Reset during DONE drops ready at once
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h30; f3 = 3'b010;
        @(posedge clk);
        @(posedge clk);
        #1;
        req = 1'b0;
        chk("done_ready", ready, 1);
        chk("done_rdata", rdata, 32'hAAAAAAAA);
        rst = 1'b1;
        #1;
        chk("rst_in_done_ready", ready, 0);
        chk("rst_in_done_rdata", rdata, 0);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        // Held request: one access every third cycle
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h10; f3 = 3'b010;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                pulses++;
                chk("hold_rdata", rdata, 32'hDEAD80EF);
            end
        end
        req = 1'b0;
        chk("hold_pulses", pulses, 4);
        repeat (2) @(negedge clk);

        // Randomized traffic, checked by the model every cycle
        for (int n = 0; n < 250; n++) begin
            logic [31:0] ra;
            ra = ($urandom_range(0, 3) << 10) | $urandom_range(0, 63);
            access(1'($urandom_range(0, 1)), ra, $urandom(), 3'($urandom_range(0, 7)), rd, mis);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
